// File: rtl/cmb_adc_pkg.sv
// Shared types and field layout for the CMB ADC capture block.
// Used by cmb_adc_capture and its result FIFO.
package cmb_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } cap_state_e;

    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned ROT_W      = 10;
    localparam int unsigned RFSW_W     = 4;
    localparam int unsigned SAMPLE_LSB = 0;
    localparam int unsigned ROT_LSB    = 12;
    localparam int unsigned RFSW_LSB   = 22;
    localparam int unsigned WORD_W     = 26;

    // Pack one tagged result into the FIFO word layout
    function automatic logic [WORD_W-1:0] pack_result(
        input logic [RFSW_W-1:0]   rf_sw,
        input logic [ROT_W-1:0]    rot,
        input logic [SAMPLE_W-1:0] sample
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[RFSW_LSB +: RFSW_W]     = rf_sw;
        w[ROT_LSB +: ROT_W]       = rot;
        w[SAMPLE_LSB +: SAMPLE_W] = sample;
        return w;
    endfunction

endpackage

// File: rtl/cmb_adc_capture_fifo.sv
// cmb_sync_fifo: synchronous FIFO with registered read data/valid and
// full/empty registered from wrap-bit pointers. Writes while full are dropped.
module cmb_sync_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q, full_q, empty_q, full_d, empty_d;
    logic             wr_ok_c, rd_ok_c;

    assign wr_ok_c = wr_en_i & ~full_q;
    assign rd_ok_c = rd_en_i & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q + PW'(wr_ok_c);
        rptr_d  = rptr_q + PW'(rd_ok_c);
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_ok_c;
            if (rd_ok_c) begin
                rd_data_q <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end

    // Storage array is not reset; only pointer-covered entries are ever read
    always_ff @(posedge clk_i) begin
        if (wr_ok_c) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/cmb_adc_capture.sv
// CMB ADC capture: one SPI conversion per adc_trg rising edge, result tagged
// with rotation/RF-switch state and queued. CMB_ADC_TESTPAT_EN adds test_mode_in.
module cmb_adc_capture
    import cmb_adc_pkg::*;
#(
    parameter int unsigned ADC_BITS   = 12,
    parameter int unsigned LEAD_ZEROS = 4,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk50_in,
    input  logic              rst_in,
    input  logic              adc_trg_in,
    input  logic [ROT_W-1:0]  rot_count_in,
    input  logic [RFSW_W-1:0] rf_sw_in,
    output logic              adc_cs_n_out,
    output logic              adc_sclk_out,
    input  logic              adc_sdata_in,
    input  logic              rd_en_in,
    output logic [WORD_W-1:0] rd_data_out,
    output logic              rd_valid_out,
    output logic              empty_out,
    output logic              full_out,
    output logic              busy_out,
    output logic              overrun_out,
    output logic              missed_trg_out
`ifdef CMB_ADC_TESTPAT_EN
    ,
    input  logic              test_mode_in
`endif
);

    localparam int unsigned NBITS = LEAD_ZEROS + ADC_BITS;
    localparam int unsigned CNT_W = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W = $clog2(NBITS);

    cap_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                trg_q, trg_edge_c;
    logic [ROT_W-1:0]    rot_q;
    logic [RFSW_W-1:0]   rf_q;
    logic [ADC_BITS-1:0] sample_q;
    logic                cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q;
    logic                overrun_q, missed_q;
    logic                shift_en_c, wr_en_c;
    logic [SAMPLE_W-1:0] sample_sel_c;
    logic [WORD_W-1:0]   wr_data_c;
    logic                fifo_full, fifo_empty;

    assign trg_edge_c = adc_trg_in & ~trg_q;

    // State register
    always_ff @(posedge clk50_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Next state: cnt_q times each phase, bit_q counts SCLK periods in SHIFT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (trg_edge_c) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(2 * SCLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        state_d = ST_QUIET;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_QUIET: begin
                if (cnt_q == CNT_W'(2 * SCLK_DIV - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pin levels follow the next state so they register with it
    always_comb begin
        cs_n_d     = 1'b1;
        sclk_d     = 1'b1;
        shift_en_c = 1'b0;
        wr_en_c    = 1'b0;
        if (state_d == ST_SETUP || state_d == ST_SHIFT) begin
            cs_n_d = 1'b0;
        end
        if (state_d == ST_SHIFT && cnt_d < CNT_W'(SCLK_DIV)) begin
            sclk_d = 1'b0;
        end
        if (state_q == ST_SHIFT && cnt_q == CNT_W'(SCLK_DIV)) begin
            shift_en_c = 1'b1;
        end
        if (state_q == ST_QUIET && cnt_q == '0) begin
            wr_en_c = 1'b1;
        end
    end

    // Datapath, pin registers and sticky flags
    always_ff @(posedge clk50_in or posedge rst_in) begin
        if (rst_in) begin
            trg_q     <= 1'b0;
            rot_q     <= '0;
            rf_q      <= '0;
            sample_q  <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            trg_q  <= adc_trg_in;
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
            busy_q <= (state_d != ST_IDLE);
            if (state_q == ST_IDLE && trg_edge_c) begin
                rot_q <= rot_count_in;
                rf_q  <= rf_sw_in;
            end
            if (trg_edge_c && state_q != ST_IDLE) begin
                missed_q <= 1'b1;
            end
            // Leading zeros shift through and fall off the top
            if (shift_en_c) begin
                sample_q <= {sample_q[ADC_BITS-2:0], adc_sdata_in};
            end
            if (wr_en_c && fifo_full) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef CMB_ADC_TESTPAT_EN
    logic [SAMPLE_W-1:0] tp_cnt_q;

    always_ff @(posedge clk50_in or posedge rst_in) begin
        if (rst_in) begin
            tp_cnt_q <= '0;
        end else if (wr_en_c) begin
            tp_cnt_q <= tp_cnt_q + SAMPLE_W'(1);
        end
    end

    assign sample_sel_c = test_mode_in ? tp_cnt_q : SAMPLE_W'(sample_q);
`else
    assign sample_sel_c = SAMPLE_W'(sample_q);
`endif

    assign wr_data_c = pack_result(rf_q, rot_q, sample_sel_c);

    cmb_sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk50_in),
        .rst_i     (rst_in),
        .wr_en_i   (wr_en_c),
        .wr_data_i (wr_data_c),
        .rd_en_i   (rd_en_in),
        .rd_data_o (rd_data_out),
        .rd_valid_o(rd_valid_out),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign adc_cs_n_out   = cs_n_q;
    assign adc_sclk_out   = sclk_q;
    assign busy_out       = busy_q;
    assign overrun_out    = overrun_q;
    assign missed_trg_out = missed_q;
    assign full_out       = fifo_full;
    assign empty_out      = fifo_empty;

endmodule
